commit_trace_monitor: RTL and testbench

Parametrised, synthesizable successor to the single-port commit/state tap on the Core test top. It observes NCOMMIT commit lanes per cycle and buffers commit records in a FIFO drained by the test host over a valid/ready port. It tracks run state (idle, run, halt, timeout) and keeps a shadow of x10/a0 to report the program exit code. It sits between Core commit outputs and the simulation/FPGA test harness.

---
 rtl/commit_trace_monitor.sv | 264 ++++++++++++++++++++++++++
 tb/tb_commit_trace_monitor.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_monitor.sv
// commit_trace_monitor
// Observes NCOMMIT commit lanes per cycle, buffers the commit records in a
// trace FIFO that the test host drains over a valid/ready port, tracks the
// run state (idle / run / halt / timeout) and keeps a shadow copy of a0 so
// the program exit code can be reported once the run halts.
// DEPTH must be a power of two, at least 2 and at least NCOMMIT; NCOMMIT is 1..4.

module commit_trace_monitor #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned NCOMMIT   = 1,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned TIMEOUT   = 1024,
   parameter logic [31:0] HALT_INST = 32'h00100073
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    io_in_start,
   input  logic [NCOMMIT-1:0]      commit_valid,
   input  logic [NCOMMIT*XLEN-1:0] commit_pc,
   input  logic [NCOMMIT*32-1:0]   commit_inst,
   input  logic [NCOMMIT-1:0]      commit_wen,
   input  logic [NCOMMIT*5-1:0]    commit_rd,
   input  logic [NCOMMIT*XLEN-1:0] commit_wdata,
   output logic                    trace_valid,
   input  logic                    trace_ready,
   output logic [XLEN-1:0]         trace_pc,
   output logic [31:0]             trace_inst,
   output logic [XLEN-1:0]         trace_wdata,
   output logic [4:0]              trace_rd,
   output logic                    trace_wen,
   output logic [1:0]              state,
   output logic                    done,
   output logic [XLEN-1:0]         halt_code,
   output logic [63:0]             commit_count,
   output logic [31:0]             drop_count,
   output logic                    overflow
);

   // Run states; the encoding is visible on the state port.
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_HALT    = 2'd2;
   localparam logic [1:0] ST_TIMEOUT = 2'd3;

   // FIFO index width and pointer width (one extra wrap bit).
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   // Per-cycle lane counts range 0..4.
   localparam int unsigned LW = 3;

   localparam logic [PW-1:0] DEPTH_P    = PW'(DEPTH);
   localparam logic [31:0]   IDLE_LIMIT = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic [XLEN-1:0] wdata;
      logic [4:0]      rd;
      logic            wen;
   } trace_rec_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [1:0]      r_state;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   trace_rec_t      r_mem [DEPTH];
   trace_rec_t      r_head;
   logic            r_trace_valid;
   logic [XLEN-1:0] r_a0;
   logic [XLEN-1:0] r_halt_code;
   logic [63:0]     r_commit_count;
   logic [31:0]     r_drop_count;
   logic            r_overflow;
   logic [31:0]     r_idle_cnt;

   // ---------------------------------------------------------------------
   // Combinational next-state signals
   // ---------------------------------------------------------------------
   logic            w_pop;
   logic [PW-1:0]   w_rd_ptr_nxt;
   logic [PW-1:0]   w_occ_after_pop;
   logic [PW-1:0]   w_free;
   logic [PW-1:0]   w_wr_ptr_nxt;
   logic [PW-1:0]   w_occ_nxt;
   logic            w_empty;
   trace_rec_t      w_rec [NCOMMIT];
   logic [AW-1:0]   w_widx [NCOMMIT];
   logic [NCOMMIT-1:0] w_acc;
   logic [LW-1:0]   w_n_eff;
   logic [LW-1:0]   w_n_acc;
   logic [LW-1:0]   w_n_drop;
   logic            w_halt;
   logic [XLEN-1:0] w_a0_nxt;
   trace_rec_t      w_first_rec;
   trace_rec_t      w_head_nxt;
   logic            w_idle_expire;
   logic [32:0]     w_drop_sum;

   // Dequeue first: a pop this cycle frees a slot for this cycle's enqueue.
   assign w_pop           = r_trace_valid && trace_ready;
   assign w_rd_ptr_nxt    = r_rd_ptr + PW'(w_pop);
   assign w_occ_after_pop = r_wr_ptr - w_rd_ptr_nxt;
   assign w_free          = DEPTH_P - w_occ_after_pop;

   // Qualify lanes, compact accepted records into FIFO slots and fold a0 writes in lane order.
   always_comb begin
      logic w_halt_seen;
      // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latches).
      w_halt_seen = 1'b0;
      w_acc       = '0;
      w_n_eff     = '0;
      w_n_acc     = '0;
      w_halt      = 1'b0;
      w_a0_nxt    = r_a0;
      w_first_rec = '0;
      for (int i = 0; i < NCOMMIT; i++) begin
         w_rec[i].pc    = commit_pc[i*XLEN +: XLEN];
         w_rec[i].inst  = commit_inst[i*32 +: 32];
         w_rec[i].wdata = commit_wdata[i*XLEN +: XLEN];
         w_rec[i].rd    = commit_rd[i*5 +: 5];
         // x0 is never written, so the host never sees a write to it.
         w_rec[i].wen   = commit_wen[i] && (commit_rd[i*5 +: 5] != 5'd0);
         // NOTE: blocking assignments here are deliberate: each lane sees the running counts of the lanes below it.
         w_widx[i]      = AW'(r_wr_ptr + PW'(w_n_eff));
         if ((r_state == ST_RUN) && commit_valid[i] && !w_halt_seen) begin
            if (32'(w_n_eff) < 32'(w_free)) begin
               w_acc[i] = 1'b1;
               if (w_n_acc == '0) begin
                  w_first_rec = w_rec[i];
               end
               w_n_acc = w_n_acc + LW'(1);
            end
            w_n_eff = w_n_eff + LW'(1);
            // a0 shadow follows every effective lane, dropped or not; the highest lane wins.
            if (commit_wen[i] && (commit_rd[i*5 +: 5] == 5'd10)) begin
               w_a0_nxt = commit_wdata[i*XLEN +: XLEN];
            end
            // The halt lane is still effective; everything above it is discarded.
            if (commit_inst[i*32 +: 32] == HALT_INST) begin
               w_halt_seen = 1'b1;
               w_halt      = 1'b1;
            end
         end
      end
   end

   assign w_n_drop     = w_n_eff - w_n_acc;
   assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_n_acc);
   assign w_occ_nxt    = w_wr_ptr_nxt - w_rd_ptr_nxt;
   assign w_empty      = (r_wr_ptr == r_rd_ptr);

   // If nothing older survives the pop, the next head is the first record written this cycle.
   assign w_head_nxt = (w_occ_after_pop == '0) ? w_first_rec : r_mem[w_rd_ptr_nxt[AW-1:0]];

   assign w_idle_expire = (TIMEOUT != 0) && (w_n_eff == '0) && (r_idle_cnt == IDLE_LIMIT);
   assign w_drop_sum    = {1'b0, r_drop_count} + 33'(w_n_drop);

   // ---------------------------------------------------------------------
   // Run-state FSM: HALT and TIMEOUT are held until reset.
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (io_in_start) r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (w_halt)             r_state <= ST_HALT;
               else if (w_idle_expire) r_state <= ST_TIMEOUT;
            end
            default: begin
               r_state <= r_state;
            end
         endcase
      end
   end

   // FIFO pointers and the registered head record presented to the host.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_trace_valid <= 1'b0;
         r_head        <= '0;
      end else begin
         r_wr_ptr      <= w_wr_ptr_nxt;
         r_rd_ptr      <= w_rd_ptr_nxt;
         r_trace_valid <= (w_occ_nxt != '0);
         if (w_occ_nxt != '0) begin
            r_head <= w_head_nxt;
         end
      end
   end

   // FIFO storage: accepted lanes land in consecutive slots starting at the write pointer.
   // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NCOMMIT; i++) begin
         if (w_acc[i]) begin
            r_mem[w_widx[i]] <= w_rec[i];
         end
      end
   end

   // a0 shadow and the exit code captured on entry to HALT.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_a0        <= '0;
         r_halt_code <= '0;
      end else begin
         r_a0 <= w_a0_nxt;
         if (w_halt) begin
            r_halt_code <= w_a0_nxt;
         end
      end
   end

   // Commit, drop and overflow statistics; drops saturate rather than wrap.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_commit_count <= '0;
         r_drop_count   <= '0;
         r_overflow     <= 1'b0;
      end else begin
         r_commit_count <= r_commit_count + 64'(w_n_eff);
         r_drop_count   <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
         if (w_n_drop != '0) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Consecutive no-commit cycles in RUN; frozen in every other state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_idle_cnt <= '0;
      end else if (r_state == ST_RUN) begin
         if (w_n_eff != '0) r_idle_cnt <= '0;
         else               r_idle_cnt <= r_idle_cnt + 32'd1;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign trace_valid  = r_trace_valid;
   assign trace_pc     = r_head.pc;
   assign trace_inst   = r_head.inst;
   assign trace_wdata  = r_head.wdata;
   assign trace_rd     = r_head.rd;
   assign trace_wen    = r_head.wen;
   assign state        = r_state;
   assign done         = ((r_state == ST_HALT) || (r_state == ST_TIMEOUT)) && w_empty;
   assign halt_code    = r_halt_code;
   assign commit_count = r_commit_count;
   assign drop_count   = r_drop_count;
   assign overflow     = r_overflow;

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Testbench for commit_trace_monitor: two commit lanes, 16-entry FIFO,
// 8-cycle timeout. Directed scenarios plus randomized traffic compared
// against a queue-based reference model of the trace monitor.

module tb_commit_trace_monitor;

   localparam int          XLEN    = 32;
   localparam int          NCOMMIT = 2;
   localparam int          DEPTH   = 16;
   localparam int          TIMEOUT = 8;
   localparam logic [31:0] HALT    = 32'h00100073;

   logic                    clock = 1'b0;
   logic                    reset = 1'b1;
   logic                    io_in_start = 1'b0;
   logic [NCOMMIT-1:0]      commit_valid = '0;
   logic [NCOMMIT*XLEN-1:0] commit_pc = '0;
   logic [NCOMMIT*32-1:0]   commit_inst = '0;
   logic [NCOMMIT-1:0]      commit_wen = '0;
   logic [NCOMMIT*5-1:0]    commit_rd = '0;
   logic [NCOMMIT*XLEN-1:0] commit_wdata = '0;
   logic                    trace_ready = 1'b0;
   logic                    trace_valid;
   logic [XLEN-1:0]         trace_pc;
   logic [31:0]             trace_inst;
   logic [XLEN-1:0]         trace_wdata;
   logic [4:0]              trace_rd;
   logic                    trace_wen;
   logic [1:0]              state;
   logic                    done;
   logic [XLEN-1:0]         halt_code;
   logic [63:0]             commit_count;
   logic [31:0]             drop_count;
   logic                    overflow;

   always #5 clock = ~clock;

   commit_trace_monitor #(
      .XLEN(XLEN), .NCOMMIT(NCOMMIT), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .HALT_INST(HALT)
   ) dut (
      .clock(clock), .reset(reset), .io_in_start(io_in_start),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
      .commit_wen(commit_wen), .commit_rd(commit_rd), .commit_wdata(commit_wdata),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_pc(trace_pc), .trace_inst(trace_inst), .trace_wdata(trace_wdata),
      .trace_rd(trace_rd), .trace_wen(trace_wen),
      .state(state), .done(done), .halt_code(halt_code),
      .commit_count(commit_count), .drop_count(drop_count), .overflow(overflow)
   );

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic        wen;
   } rec_t;

   rec_t              m_q[$];
   int                m_state;
   logic [31:0]       m_a0;
   logic [31:0]       m_halt_code;
   longint unsigned   m_cc;
   longint unsigned   m_drop;
   bit                m_ovf;
   int                m_idle;

   function automatic void model_reset();
      m_q.delete();
      m_state = 0; m_a0 = 0; m_halt_code = 0;
      m_cc = 0; m_drop = 0; m_ovf = 0; m_idle = 0;
   endfunction

   // One clock of the monitor, from the inputs currently applied.
   function automatic void model_step();
      rec_t r;
      bit   halted;
      int   neff;
      if (m_q.size() != 0 && trace_ready) void'(m_q.pop_front());
      if (m_state == 0) begin
         if (io_in_start) m_state = 1;
      end else if (m_state == 1) begin
         halted = 0;
         neff   = 0;
         for (int i = 0; i < NCOMMIT; i++) begin
            if (commit_valid[i] && !halted) begin
               r.pc    = commit_pc[i*32 +: 32];
               r.inst  = commit_inst[i*32 +: 32];
               r.wdata = commit_wdata[i*32 +: 32];
               r.rd    = commit_rd[i*5 +: 5];
               r.wen   = commit_wen[i] && (r.rd != 0);
               neff++;
               if (m_q.size() < DEPTH) m_q.push_back(r);
               else begin
                  m_ovf = 1;
                  if (m_drop < 64'hFFFF_FFFF) m_drop++;
               end
               if (commit_wen[i] && r.rd == 5'd10) m_a0 = r.wdata;
               if (r.inst == HALT) halted = 1;
            end
         end
         m_cc += neff;
         if (neff > 0) m_idle = 0;
         else begin
            if (m_idle == TIMEOUT - 1) m_state = 3;
            m_idle++;
         end
         if (halted) begin
            m_state     = 2;
            m_halt_code = m_a0;
         end
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic cycle();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [31:0] pc, input logic [31:0] inst,
                           input logic wen, input logic [4:0] rd, input logic [31:0] wdata);
      commit_valid[i]           = 1'b1;
      commit_pc[i*32 +: 32]     = pc;
      commit_inst[i*32 +: 32]   = inst;
      commit_wen[i]             = wen;
      commit_rd[i*5 +: 5]       = rd;
      commit_wdata[i*32 +: 32]  = wdata;
   endtask

   task automatic clear_lanes();
      commit_valid = '0;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] v;
      v = $urandom;
      if (v == HALT) v = v ^ 32'h1;
      return v;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      io_in_start = 1'b0;
      trace_ready = 1'b0;
      clear_lanes();
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic start_run();
      io_in_start = 1'b1;
      cycle();
      io_in_start = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
      n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL reset_trace_valid: got %b want 0", trace_valid); end
      n_cmp++; if ({trace_pc, trace_inst, trace_wdata, trace_rd, trace_wen} !== '0) begin n_err++; $display("FAIL reset_trace_data: got pc=%h inst=%h want 0", trace_pc, trace_inst); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (halt_code !== 32'd0) begin n_err++; $display("FAIL reset_halt_code: got %h want 0", halt_code); end
      n_cmp++; if (commit_count !== 64'd0 || drop_count !== 32'd0 || overflow !== 1'b0) begin n_err++; $display("FAIL reset_counters: got cc=%0d drop=%0d ovf=%b want 0", commit_count, drop_count, overflow); end
      // Commits presented while IDLE are ignored.
      set_lane(0, 32'h8000_0000, rand_inst(), 1'b1, 5'd10, 32'd3);
      cycle();
      clear_lanes();
      n_cmp++; if (commit_count !== 64'd0 || trace_valid !== 1'b0) begin n_err++; $display("FAIL idle_ignores_commits: got cc=%0d valid=%b want 0/0", commit_count, trace_valid); end
   endtask

   task automatic test_basic_halt();
      do_reset();
      start_run();
      n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL basic_start: got %0d want 1", state); end
      set_lane(0, 32'h8000_0000, 32'h0050_0513, 1'b1, 5'd10, 32'd5);
      cycle();
      clear_lanes();
      set_lane(0, 32'h8000_0004, HALT, 1'b0, 5'd0, 32'd0);
      cycle();
      clear_lanes();
      n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL basic_state: got %0d want 2", state); end
      n_cmp++; if (halt_code !== 32'd5) begin n_err++; $display("FAIL basic_halt_code: got %0d want 5", halt_code); end
      n_cmp++; if (commit_count !== 64'd2) begin n_err++; $display("FAIL basic_commit_count: got %0d want 2", commit_count); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_early: got %b want 0", done); end
      n_cmp++; if (trace_valid !== 1'b1 || trace_pc !== 32'h8000_0000 || trace_wen !== 1'b1 || trace_rd !== 5'd10 || trace_wdata !== 32'd5) begin n_err++; $display("FAIL basic_rec0: got v=%b pc=%h wen=%b rd=%0d wd=%0d want 1/80000000/1/10/5", trace_valid, trace_pc, trace_wen, trace_rd, trace_wdata); end
      trace_ready = 1'b1;
      cycle();
      n_cmp++; if (trace_valid !== 1'b1 || trace_pc !== 32'h8000_0004 || trace_inst !== HALT) begin n_err++; $display("FAIL basic_rec1: got v=%b pc=%h inst=%h want 1/80000004/%h", trace_valid, trace_pc, trace_inst, HALT); end
      cycle();
      trace_ready = 1'b0;
      n_cmp++; if (trace_valid !== 1'b0 || done !== 1'b1) begin n_err++; $display("FAIL basic_done: got valid=%b done=%b want 0/1", trace_valid, done); end
   endtask

   task automatic test_overflow();
      do_reset();
      start_run();
      for (int k = 0; k < 20; k++) begin
         set_lane(0, 32'h1000 + 32'(4*k), rand_inst(), 1'($urandom), 5'($urandom), $urandom);
         cycle();
      end
      clear_lanes();
      n_cmp++; if (drop_count !== 32'd4) begin n_err++; $display("FAIL ovf_drop_count: got %0d want 4", drop_count); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      n_cmp++; if (commit_count !== 64'd20) begin n_err++; $display("FAIL ovf_commit_count: got %0d want 20", commit_count); end
      trace_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         n_cmp++; if (trace_valid !== 1'b1 || trace_pc !== 32'h1000 + 32'(4*k)) begin n_err++; $display("FAIL ovf_drain_pc[%0d]: got v=%b pc=%h want 1/%h", k, trace_valid, trace_pc, 32'h1000 + 32'(4*k)); end
         if (m_q.size() != 0) begin
            n_cmp++; if ({trace_inst, trace_wdata, trace_rd, trace_wen} !== {m_q[0].inst, m_q[0].wdata, m_q[0].rd, m_q[0].wen}) begin n_err++; $display("FAIL ovf_drain_rec[%0d]: got %h/%h/%0d/%b want %h/%h/%0d/%b", k, trace_inst, trace_wdata, trace_rd, trace_wen, m_q[0].inst, m_q[0].wdata, m_q[0].rd, m_q[0].wen); end
         end
         cycle();
      end
      trace_ready = 1'b0;
      n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got %b want 0", trace_valid); end
   endtask

   task automatic test_dual_lane();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'h200; exp_pc[1] = 32'h204; exp_pc[2] = 32'h208;
      do_reset();
      start_run();
      set_lane(0, 32'h200, 32'h0070_0513, 1'b1, 5'd10, 32'd7);
      set_lane(1, 32'h204, 32'h0090_0513, 1'b1, 5'd10, 32'd9);
      cycle();
      clear_lanes();
      set_lane(0, 32'h208, HALT, 1'b0, 5'd0, 32'd0);
      set_lane(1, 32'h20c, 32'h0550_0513, 1'b1, 5'd10, 32'h55);
      cycle();
      clear_lanes();
      n_cmp++; if (commit_count !== 64'd3) begin n_err++; $display("FAIL dual_commit_count: got %0d want 3", commit_count); end
      n_cmp++; if (halt_code !== 32'd9) begin n_err++; $display("FAIL dual_halt_code: got %0d want 9", halt_code); end
      n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL dual_state: got %0d want 2", state); end
      n_cmp++; if (drop_count !== 32'd0) begin n_err++; $display("FAIL dual_drop: got %0d want 0", drop_count); end
      trace_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (trace_valid !== 1'b1 || trace_pc !== exp_pc[k]) begin n_err++; $display("FAIL dual_order[%0d]: got v=%b pc=%h want 1/%h", k, trace_valid, trace_pc, exp_pc[k]); end
         cycle();
      end
      trace_ready = 1'b0;
      n_cmp++; if (trace_valid !== 1'b0 || done !== 1'b1) begin n_err++; $display("FAIL dual_done: got valid=%b done=%b want 0/1", trace_valid, done); end
   endtask

   task automatic test_timeout();
      do_reset();
      start_run();
      trace_ready = 1'b1;
      set_lane(0, 32'h300, rand_inst(), 1'b0, 5'd0, 32'd0);
      cycle();
      clear_lanes();
      repeat (7) cycle();
      n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL timeout_gap7_first: got %0d want 1", state); end
      set_lane(0, 32'h304, rand_inst(), 1'b0, 5'd0, 32'd0);
      cycle();
      clear_lanes();
      n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL timeout_commit_rescues: got %0d want 1", state); end
      repeat (7) cycle();
      n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL timeout_gap7: got %0d want 1", state); end
      cycle();
      n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL timeout_gap8: got %0d want 3", state); end
      // Terminal: start and commits are ignored, FIFO already drained.
      io_in_start = 1'b1;
      set_lane(0, 32'h308, rand_inst(), 1'b0, 5'd0, 32'd0);
      cycle();
      io_in_start = 1'b0;
      clear_lanes();
      n_cmp++; if (state !== 2'd3 || commit_count !== 64'd2) begin n_err++; $display("FAIL timeout_terminal: got state=%0d cc=%0d want 3/2", state, commit_count); end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL timeout_done: got %b want 1", done); end
      trace_ready = 1'b0;
   endtask

   task automatic test_full_pop_push();
      int pops;
      do_reset();
      start_run();
      for (int k = 0; k < 16; k++) begin
         set_lane(0, 32'h400 + 32'(4*k), rand_inst(), 1'b0, 5'd0, 32'd0);
         cycle();
      end
      clear_lanes();
      n_cmp++; if (trace_valid !== 1'b1 || drop_count !== 32'd0) begin n_err++; $display("FAIL full_fill: got valid=%b drop=%0d want 1/0", trace_valid, drop_count); end
      trace_ready = 1'b1;
      set_lane(0, 32'h440, rand_inst(), 1'b0, 5'd0, 32'd0);
      cycle();
      trace_ready = 1'b0;
      clear_lanes();
      n_cmp++; if (drop_count !== 32'd0 || overflow !== 1'b0) begin n_err++; $display("FAIL full_pop_push_drop: got drop=%0d ovf=%b want 0/0", drop_count, overflow); end
      n_cmp++; if (trace_pc !== 32'h404) begin n_err++; $display("FAIL full_pop_push_head: got %h want 404", trace_pc); end
      // Still full: a lone push without a pop must drop.
      set_lane(0, 32'h444, rand_inst(), 1'b0, 5'd0, 32'd0);
      cycle();
      clear_lanes();
      n_cmp++; if (drop_count !== 32'd1 || overflow !== 1'b1) begin n_err++; $display("FAIL full_still_full: got drop=%0d ovf=%b want 1/1", drop_count, overflow); end
      trace_ready = 1'b1;
      pops = 0;
      while (trace_valid === 1'b1 && pops < 40) begin
         n_cmp++; if (trace_pc !== 32'h404 + 32'(4*pops)) begin n_err++; $display("FAIL full_drain_pc[%0d]: got %h want %h", pops, trace_pc, 32'h404 + 32'(4*pops)); end
         pops++;
         cycle();
      end
      trace_ready = 1'b0;
      n_cmp++; if (pops != 16) begin n_err++; $display("FAIL full_occupancy: got %0d records want 16", pops); end
   endtask

   task automatic test_async_reset();
      do_reset();
      start_run();
      for (int k = 0; k < 5; k++) begin
         set_lane(0, 32'h500 + 32'(4*k), rand_inst(), 1'b1, 5'd10, 32'(k + 1));
         cycle();
      end
      clear_lanes();
      n_cmp++; if (trace_valid !== 1'b1 || commit_count !== 64'd5) begin n_err++; $display("FAIL areset_pre: got valid=%b cc=%0d want 1/5", trace_valid, commit_count); end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", trace_valid); end
      n_cmp++; if (state !== 2'd0 || done !== 1'b0) begin n_err++; $display("FAIL areset_state: got state=%0d done=%b want 0/0", state, done); end
      n_cmp++; if (commit_count !== 64'd0 || drop_count !== 32'd0 || overflow !== 1'b0 || halt_code !== 32'd0) begin n_err++; $display("FAIL areset_counters: got cc=%0d drop=%0d ovf=%b hc=%h want all 0", commit_count, drop_count, overflow, halt_code); end
      n_cmp++; if (trace_pc !== 32'd0 || trace_wdata !== 32'd0) begin n_err++; $display("FAIL areset_data: got pc=%h wd=%h want 0", trace_pc, trace_wdata); end
      model_reset();
      @(posedge clock); #1;
      reset = 1'b0;
      cycle();
      n_cmp++; if (trace_valid !== 1'b0 || state !== 2'd0) begin n_err++; $display("FAIL areset_after: got valid=%b state=%0d want 0/0", trace_valid, state); end
   endtask

   task automatic test_random(input int cycles);
      int vthr;
      int rthr;
      for (int ep = 0; ep < 3; ep++) begin
         vthr = (ep == 2) ? 2 : 6;
         rthr = 2 + 3 * ep;
         do_reset();
         start_run();
         for (int c = 0; c < cycles; c++) begin
            io_in_start = ($urandom_range(0, 15) == 0);
            trace_ready = ($urandom_range(0, 9) < rthr);
            clear_lanes();
            for (int i = 0; i < NCOMMIT; i++) begin
               if ($urandom_range(0, 9) < vthr)
                  set_lane(i, $urandom, ($urandom_range(0, 149) == 0) ? HALT : rand_inst(),
                           1'($urandom),
                           ($urandom_range(0, 3) == 0) ? 5'd10 : 5'($urandom_range(0, 31)),
                           $urandom);
            end
            cycle();
            n_cmp++; if (state !== 2'(m_state)) begin n_err++; $display("FAIL rand_state ep%0d c%0d: got %0d want %0d", ep, c, state, m_state); end
            n_cmp++; if (trace_valid !== (m_q.size() != 0)) begin n_err++; $display("FAIL rand_valid ep%0d c%0d: got %b want %b", ep, c, trace_valid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
               n_cmp++; if ({trace_pc, trace_inst, trace_wdata, trace_rd, trace_wen} !== {m_q[0].pc, m_q[0].inst, m_q[0].wdata, m_q[0].rd, m_q[0].wen}) begin n_err++; $display("FAIL rand_head ep%0d c%0d: got %h/%h/%h/%0d/%b want %h/%h/%h/%0d/%b", ep, c, trace_pc, trace_inst, trace_wdata, trace_rd, trace_wen, m_q[0].pc, m_q[0].inst, m_q[0].wdata, m_q[0].rd, m_q[0].wen); end
            end
            n_cmp++; if (commit_count !== 64'(m_cc) || drop_count !== 32'(m_drop) || overflow !== m_ovf) begin n_err++; $display("FAIL rand_stats ep%0d c%0d: got cc=%0d drop=%0d ovf=%b want %0d/%0d/%b", ep, c, commit_count, drop_count, overflow, m_cc, m_drop, m_ovf); end
            n_cmp++; if (halt_code !== m_halt_code) begin n_err++; $display("FAIL rand_halt_code ep%0d c%0d: got %h want %h", ep, c, halt_code, m_halt_code); end
            n_cmp++; if (done !== (m_state >= 2 && m_q.size() == 0)) begin n_err++; $display("FAIL rand_done ep%0d c%0d: got %b want %b", ep, c, done, (m_state >= 2 && m_q.size() == 0)); end
         end
         io_in_start = 1'b0;
         trace_ready = 1'b0;
         clear_lanes();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic_halt();
      test_overflow();
      test_dual_lane();
      test_timeout();
      test_full_pop_push();
      test_async_reset();
      test_random(250);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1, "watchdog");
   end

endmodule
